// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift register sequencing controller.
// Holds the controller state encoding and the hex to 7-segment decoder.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } seq_state_t;

    // Segment order is gfedcba, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/shift_datapath.sv
// NBITS-bit shift register with clear, parallel load and shift-right-with-serial-in.
// Command priority is clear, then load, then shift.
module shift_datapath #(
    parameter int NBITS = 4
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [NBITS-1:0] load_val,
    input  logic             shift_in,
    output logic             sr_lsb,
    output logic [NBITS-1:0] sr_next
);

    logic [NBITS-1:0] sr_q;
    logic [NBITS-1:0] sr_d;

    // The post-shift value is exported so the controller can capture a
    // received word on the same edge as the final shift.
    always_comb begin
        sr_next = {shift_in, sr_q[NBITS-1:1]};
        sr_d    = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (load) begin
            sr_d = load_val;
        end else if (shift) begin
            sr_d = sr_next;
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_lsb = sr_q[0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Turns a start rise into a full serial transmit or receive transaction on
// the shift register datapath, with busy/done status and a 7-segment image.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic                   clk_2,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [NBITS-1:0]       data_in,
    input  logic                   serial_in,
    output logic                   serial_out,
    output logic                   busy,
    output logic                   done,
    output logic [NBITS-1:0]       data_out,
    output logic [$clog2(NBITS):0] bit_cnt,
    output logic [7:0]             seg
);

    localparam int CNT_W = $clog2(NBITS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

    seq_state_t       state_q, state_d;
    logic             start_q, start_d;
    logic             mode_q, mode_d;
    logic [NBITS-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0] data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             rise;
    logic             dp_clear;
    logic             dp_load;
    logic             dp_shift;
    logic             dp_shift_in;
    logic             sr_lsb;
    logic [NBITS-1:0] sr_next;
    logic [3:0]       seg_nib;

    assign rise        = start & ~start_q;
    assign dp_clear    = (state_q == LOAD) &  mode_q;
    assign dp_load     = (state_q == LOAD) & ~mode_q;
    assign dp_shift    = (state_q == SHIFT);
    assign dp_shift_in = mode_q & serial_in;

    shift_datapath #(
        .NBITS(NBITS)
    ) u_datapath (
        .clk_2    (clk_2),
        .reset_n  (reset_n),
        .clear    (dp_clear),
        .load     (dp_load),
        .shift    (dp_shift),
        .load_val (hold_q),
        .shift_in (dp_shift_in),
        .sr_lsb   (sr_lsb),
        .sr_next  (sr_next)
    );

    // A rise outside IDLE is simply dropped; mode and data are only captured here.
    always_comb begin
        state_d    = state_q;
        start_d    = start;
        mode_d     = mode_q;
        hold_d     = hold_q;
        bit_cnt_d  = bit_cnt_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    mode_d  = mode;
                    hold_d  = data_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bit_cnt_d = '0;
                if (!mode_q) begin
                    data_out_d = hold_q;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    if (mode_q) begin
                        data_out_d = sr_next;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // start_q resets high so a start held through reset release is not a rise.
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b1;
            mode_q     <= 1'b0;
            hold_q     <= '0;
            bit_cnt_q  <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            mode_q     <= mode_d;
            hold_q     <= hold_d;
            bit_cnt_q  <= bit_cnt_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign seg_nib    = 4'(data_out_q);
    assign serial_out = (state_q == SHIFT) & ~mode_q & sr_lsb;
    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_out_q;
    assign bit_cnt    = bit_cnt_q;
    assign seg        = {busy_q, hex_to_seg(seg_nib)};

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: a table of transmit/receive transactions
// plus hand sequences for reset, held start, interference and abort.
module tb_shift_seq_ctrl;

    localparam int NBITS = 4;

    logic             clk_2 = 1'b0;
    logic             reset_n;
    logic             start;
    logic             mode;
    logic [NBITS-1:0] data_in;
    logic             serial_in;
    logic             serial_out;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] data_out;
    logic [2:0]       bit_cnt;
    logic [7:0]       seg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       m;
        logic [3:0] d;
        logic [3:0] sin;
        logic [3:0] exp_out;
        logic [6:0] exp_seg;
    } vec_t;

    vec_t vecs[6];

    always #5 clk_2 = ~clk_2;

    shift_seq_ctrl #(
        .NBITS(NBITS)
    ) dut (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .data_in    (data_in),
        .serial_in  (serial_in),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .bit_cnt    (bit_cnt),
        .seg        (seg)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // One full transaction; sin[i] is the i-th serial bit offered in SHIFT.
    task automatic applyStimulus(input logic m, input logic [3:0] d, input logic [3:0] sin,
                                 input logic [3:0] exp_out, input logic [6:0] exp_seg,
                                 input bit hold_start, input bit meddle);
        mode      = m;
        data_in   = d;
        serial_in = 1'b0;
        start     = 1'b1;
        tick();
        checkOutput("load_busy", 32'(busy), 32'd1);
        checkOutput("load_done", 32'(done), 32'd0);
        checkOutput("load_serial_out", 32'(serial_out), 32'd0);
        if (!hold_start) start = 1'b0;
        tick();
        for (int i = 0; i < NBITS; i++) begin
            checkOutput("shift_serial_out", 32'(serial_out), m ? 32'd0 : 32'(d[i]));
            checkOutput("shift_bit_cnt", 32'(bit_cnt), 32'(i));
            checkOutput("shift_busy", 32'(busy), 32'd1);
            checkOutput("shift_done", 32'(done), 32'd0);
            if (!m) checkOutput("tx_data_out_early", 32'(data_out), 32'(d));
            serial_in = sin[i];
            if (meddle && i == 1) begin
                start   = 1'b1;
                mode    = ~m;
                data_in = ~d;
            end
            if (meddle && i == 2) start = 1'b0;
            tick();
        end
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("done_data_out", 32'(data_out), 32'(exp_out));
        checkOutput("done_seg", 32'(seg), 32'({1'b1, exp_seg}));
        checkOutput("done_bit_cnt", 32'(bit_cnt), 32'd4);
        checkOutput("done_serial_out", 32'(serial_out), 32'd0);
        serial_in = 1'b0;
        tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_seg", 32'(seg), 32'({1'b0, exp_seg}));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{m: 1'b0, d: 4'hB, sin: 4'h0, exp_out: 4'hB, exp_seg: 7'h7C};
        vecs[1] = '{m: 1'b1, d: 4'h0, sin: 4'h6, exp_out: 4'h6, exp_seg: 7'h7D};
        vecs[2] = '{m: 1'b0, d: 4'h5, sin: 4'hF, exp_out: 4'h5, exp_seg: 7'h6D};
        vecs[3] = '{m: 1'b1, d: 4'hF, sin: 4'hA, exp_out: 4'hA, exp_seg: 7'h77};
        vecs[4] = '{m: 1'b0, d: 4'h0, sin: 4'h0, exp_out: 4'h0, exp_seg: 7'h3F};
        vecs[5] = '{m: 1'b1, d: 4'h3, sin: 4'h9, exp_out: 4'h9, exp_seg: 7'h6F};

        reset_n   = 1'b0;
        start     = 1'b1;
        mode      = 1'b0;
        data_in   = '0;
        serial_in = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_seg", 32'(seg), 32'h3F);
        checkOutput("rst_serial_out", 32'(serial_out), 32'd0);
        checkOutput("rst_bit_cnt", 32'(bit_cnt), 32'd0);

        // start is still high at release, so nothing may begin.
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_held_start_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].m, vecs[v].d, vecs[v].sin, vecs[v].exp_out, vecs[v].exp_seg, 1'b0, 1'b0);
        end

        applyStimulus(1'b0, 4'h9, 4'h0, 4'h9, 7'h6F, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h0, 4'hC, 4'hC, 7'h39, 1'b0, 1'b1);

        applyStimulus(1'b0, 4'h2, 4'h0, 4'h2, 7'h5B, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("held_start_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        tick();
        checkOutput("held_low_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        checkOutput("retrigger_busy", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("retrigger_end_busy", 32'(busy), 32'd0);
        checkOutput("retrigger_data_out", 32'(data_out), 32'h2);

        mode      = 1'b1;
        data_in   = 4'h0;
        serial_in = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("abort_pre_bit_cnt", 32'(bit_cnt), 32'd1);
        reset_n = 1'b0;
        tick();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_data_out", 32'(data_out), 32'd0);
        checkOutput("abort_bit_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("abort_seg", 32'(seg), 32'h3F);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("abort_no_done", 32'(done), 32'd0);
            checkOutput("abort_stay_idle", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the board's NBITS-bit shift register datapath. It turns a single start request into a complete serial transaction. In transmit mode it loads a parallel word and shifts it out LSB-first. In receive mode it clears the register, shifts NBITS serial bits in at the MSB, and presents the assembled word. It sits between the switch/LED/7-segment I/O of `top` and the shift register, and exposes busy/done status for the LCD debug fields.

## Interface

Parameters:
- `NBITS`, default 4: shift register width; minimum 2.

Ports (name, direction, width, meaning):
- `clk_2`, in, 1: system clock, single clock domain.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: request level. Only a 0→1 transition triggers an operation.
- `mode`, in, 1: 0 = transmit, 1 = receive. Captured on the start rise.
- `data_in`, in, NBITS: parallel word to transmit. Captured on the start rise.
- `serial_in`, in, 1: receive bit stream.
- `serial_out`, out, 1: transmit bit stream.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `data_out`, out, NBITS: last transmitted or received word.
- `bit_cnt`, out, $clog2(NBITS)+1: number of shifts completed in the current operation.
- `seg`, out, 8: 7-segment image of `data_out[3:0]`. Bits [6:0] are gfedcba, active-high; bit 7 = `busy`.

## Operation

- **Start detect:** `start_q` registers `start` every cycle. `rise = start & ~start_q`. A rise is acted on only in IDLE; a rise in any other state is discarded.
- **IDLE:**
  - On `rise`: latch `mode` into `mode_q` and `data_in` into `hold`, then go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD (1 cycle):**
  - `sr <= mode_q ? 0 : hold`.
  - `bit_cnt <= 0`.
  - Next state SHIFT.
  - If `mode_q = 0`, `data_out <= hold`.
- **SHIFT (exactly NBITS cycles):** each edge performs one shift and increments `bit_cnt`.
  - Transmit: `sr <= {1'b0, sr[NBITS-1:1]}`.
  - Receive: `sr <= {serial_in, sr[NBITS-1:1]}`.
  - On the edge where `bit_cnt = NBITS-1` (the last shift), go to DONE. In receive mode this edge also loads `data_out` with the post-shift `sr`.
- **DONE (1 cycle):** `done = 1`. Next state IDLE unconditionally.
- **serial_out:** combinational; equals `sr[0]` when state = SHIFT and `mode_q = 0`, otherwise 0. Bits leave LSB-first.
- **Receive bit order:** the first bit sampled ends up in `data_out[0]`.
- **Input sampling:** `mode` and `data_in` are ignored after the rise edge; mid-operation changes have no effect.
- **seg decode (hex):** 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71.
- **Reset values:**
  - state IDLE; `sr`, `hold`, `mode_q`, `bit_cnt`, `data_out` all 0.
  - `start_q` = 1, so a `start` held high through reset release does not trigger an operation.
  - Outputs: `busy` 0, `done` 0, `serial_out` 0, `seg` 8'h3F.
- **Reset mid-operation:**
  - The next edge returns all state to reset values.
  - No `done` pulse is issued for the aborted operation.
  - `data_out` is cleared.

## Timing

- Edge T samples the rise. State is LOAD during cycle T+1 and SHIFT during cycles T+2 … T+NBITS+1. DONE occupies cycle T+NBITS+2, and IDLE resumes at T+NBITS+3.
- `busy` is high for NBITS+2 cycles; for NBITS=4 that is 6 cycles.
- Transmit `serial_out` during the SHIFT cycles is `hold[0]`, `hold[1]`, …, `hold[NBITS-1]`. Transmit `data_out` is valid from cycle T+2.
- Receive `serial_in` is sampled at the end of each SHIFT cycle. Receive `data_out` is valid in the DONE cycle, simultaneous with `done`.
- Earliest accepted next rise: the first edge in IDLE, at the end of cycle T+NBITS+3 at the soonest. `start` must have been low on at least one edge in between.

## Structure

- Package `shift_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} seq_state_t`.
  - Function `hex_to_seg(logic [3:0]) → logic [6:0]`.
- Sub-module `shift_datapath`: holds `sr` and implements the clear, load, and shift-right-with-serial-in operations under controller commands.
- The top-level FSM, `start` edge detector, `bit_cnt` counter, and output registers live in `shift_seq_ctrl`.

## Test plan

1. **Reset:** `reset_n` = 0 for 2 cycles with `start` = 1 → `busy` 0, `done` 0, `data_out` 0, `seg` 8'h3F. After release, no operation starts while `start` stays 1.
2. **Transmit:** `mode` 0, `data_in` 4'hB, `start` 0→1 → `busy` 6 cycles, `serial_out` 1,1,0,1 in SHIFT cycles, single `done` pulse at cycle T+6, `data_out` 4'hB, `seg[6:0]` 7'h7C.
3. **Receive:** `mode` 1, `serial_in` 0,1,1,0 in SHIFT cycles → `data_out` 4'h6 with `done`, `seg[6:0]` 7'h7D, `serial_out` held 0 throughout.
4. **Held start:** `start` kept high past DONE → no second operation. Toggling `start` 0→1 afterwards starts a new one.
5. **Interference while busy:** `start` re-pulsed, `mode` flipped, and `data_in` changed during SHIFT → operation completes unchanged with the originally captured values.
6. **Abort:** `reset_n` = 0 in the second SHIFT cycle of a receive → state IDLE, `data_out` 0, `bit_cnt` 0, no `done` pulse.
